// File: rtl/uc_pkg.sv
// Shared definitions for the unit-clause path: literal space, queue depth,
// engine count and helpers that split a literal into variable and polarity.
package uc_pkg;

  localparam int UC_LENGTH = 512;
  localparam int UCQ_SIZE  = 64;
  localparam int NUM_ENG   = 4;
  localparam int LIT_W     = $clog2(UC_LENGTH);
  localparam int CNT_W     = 16;

  typedef logic [LIT_W-1:0] lit_t;

  // Variable index lives above the polarity bit.
  function automatic logic [LIT_W-2:0] lit_var(input lit_t l);
    return l[LIT_W-1:1];
  endfunction

  // Bit 0 set means the negative literal.
  function automatic logic lit_pol(input lit_t l);
    return l[0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping
// around. N must be a power of two so the index arithmetic wraps naturally.
module rr_arbiter #(
  parameter int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx;
  logic          found;

  // Scan the requesters cyclically from ptr and keep only the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + IW'(k);
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: grants one engine report per cycle in round-robin
// order, checks it against the assignment scoreboard and either pushes it to
// the unit-clause queue, counts it as a duplicate, or latches a conflict.
module uc_arbiter #(
  parameter int NUM_ENG   = uc_pkg::NUM_ENG,
  parameter int UC_LENGTH = uc_pkg::UC_LENGTH,
  parameter int CNT_W     = uc_pkg::CNT_W,
  localparam int LIT_W    = $clog2(UC_LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_ENG-1:0]       eng_valid,
  input  logic [NUM_ENG*LIT_W-1:0] eng_lit,
  output logic [NUM_ENG-1:0]       eng_ready,
  input  logic                     clear,
  input  logic                     full,
  output logic                     push,
  output logic [LIT_W-1:0]         uca2ucq,
  output logic                     conflict,
  output logic [LIT_W-1:0]         conflict_lit,
  output logic [CNT_W-1:0]         dup_cnt
);

  import uc_pkg::*;

  localparam int NUM_VARS = UC_LENGTH / 2;
  localparam int IW       = $clog2(NUM_ENG);

  // Scoreboard is kept in flops: it is read combinationally in the grant
  // cycle and must be wiped in a single cycle on clear.
  logic [NUM_VARS-1:0] assigned_q;
  logic [NUM_VARS-1:0] value_q;

  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
  logic             conflict_q, conflict_d;
  logic [LIT_W-1:0] conflict_lit_q, conflict_lit_d;

  logic               eligible;
  logic [NUM_ENG-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               any_gnt;
  logic [LIT_W-1:0]   gnt_lit;
  logic [LIT_W-2:0]   gnt_var;
  logic               gnt_pol;
  logic               is_new;
  logic               is_dup;
  logic               is_conf;

  // Nothing is granted while reset, clear, back-pressure or a conflict holds.
  assign eligible = !rst && !clear && !full && !conflict_q;

  rr_arbiter #(
    .N (NUM_ENG)
  ) u_rr (
    .req     (eng_valid),
    .ptr     (rr_ptr_q),
    .en      (eligible),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt = |gnt;

  // Select the granted engine's literal (one-hot mux, zero when idle).
  always_comb begin
    gnt_lit = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (gnt[i]) begin
        gnt_lit = eng_lit[i*LIT_W +: LIT_W];
      end
    end
  end

  assign gnt_var = gnt_lit[LIT_W-1:1];
  assign gnt_pol = gnt_lit[0];

  assign is_new  = any_gnt && !assigned_q[gnt_var];
  assign is_dup  = any_gnt &&  assigned_q[gnt_var] && (value_q[gnt_var] == gnt_pol);
  assign is_conf = any_gnt &&  assigned_q[gnt_var] && (value_q[gnt_var] != gnt_pol);

  assign eng_ready    = gnt;
  assign push         = is_new;
  assign uca2ucq      = is_new ? gnt_lit : '0;
  assign conflict     = conflict_q;
  assign conflict_lit = conflict_lit_q;
  assign dup_cnt      = dup_cnt_q;

  // Next-state for pointer, duplicate counter and conflict capture.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    dup_cnt_d      = dup_cnt_q;
    conflict_d     = conflict_q;
    conflict_lit_d = conflict_lit_q;
    if (any_gnt) begin
      rr_ptr_d = gnt_idx + IW'(1);
    end
    if (is_dup && (dup_cnt_q != '1)) begin
      dup_cnt_d = dup_cnt_q + CNT_W'(1);
    end
    if (is_conf) begin
      conflict_d     = 1'b1;
      conflict_lit_d = gnt_lit;
    end
  end

  // Pointer and duplicate counter survive clear; only reset returns them to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      dup_cnt_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      dup_cnt_q <= dup_cnt_d;
    end
  end

  // Scoreboard and conflict state: wiped by reset or clear, else updated by the grant.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      assigned_q     <= '0;
      value_q        <= '0;
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
    end else begin
      conflict_q     <= conflict_d;
      conflict_lit_q <= conflict_lit_d;
      if (is_new) begin
        assigned_q[gnt_var] <= 1'b1;
        value_q[gnt_var]    <= gnt_pol;
      end
    end
  end

endmodule

// File: tb/tb_uc_arbiter.sv
// Self-checking bench for uc_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural scoreboard model.
module tb_uc_arbiter;

  localparam int N  = 4;
  localparam int LW = 9;
  localparam int CW = 16;
  localparam int NV = 256;
  localparam int DUP_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          full;
  logic [N-1:0]  eng_valid;
  logic [N*LW-1:0] eng_lit;
  logic [N-1:0]  eng_ready;
  logic          push;
  logic [LW-1:0] uca2ucq;
  logic          conflict;
  logic [LW-1:0] conflict_lit;
  logic [CW-1:0] dup_cnt;

  logic [LW-1:0] lits [N];

  int n_tests = 0;
  int n_fail  = 0;
  bit verbose = 1'b1;

  // Model state
  bit m_asg [NV];
  bit m_val [NV];
  int m_ptr;
  int m_dup;
  bit m_conf;
  int m_clit;

  always #5 clk = ~clk;

  always_comb begin
    eng_lit = '0;
    for (int i = 0; i < N; i++) eng_lit[i*LW +: LW] = lits[i];
  end

  uc_arbiter #(
    .NUM_ENG   (N),
    .UC_LENGTH (512),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .eng_valid    (eng_valid),
    .eng_lit      (eng_lit),
    .eng_ready    (eng_ready),
    .clear        (clear),
    .full         (full),
    .push         (push),
    .uca2ucq      (uca2ucq),
    .conflict     (conflict),
    .conflict_lit (conflict_lit),
    .dup_cnt      (dup_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_asg[v] = 1'b0;
      m_val[v] = 1'b0;
    end
    m_ptr  = 0;
    m_dup  = 0;
    m_conf = 1'b0;
    m_clit = 0;
  endtask

  // One clock: predict, compare mid-cycle, then advance the model at the edge.
  task automatic step(input string ph);
    int g;
    int lit;
    int v;
    int p;
    int kind;  // 0 none, 1 new, 2 duplicate, 3 conflict
    logic [N-1:0] er;
    #2;
    g = -1;
    lit = 0;
    v = 0;
    p = 0;
    kind = 0;
    er = '0;
    if (!rst && !clear && !full && !m_conf) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && eng_valid[i]) g = i;
      end
    end
    if (g >= 0) begin
      er[g] = 1'b1;
      lit = int'(lits[g]);
      v = lit / 2;
      p = lit % 2;
      if (!m_asg[v]) kind = 1;
      else if (int'(m_val[v]) == p) kind = 2;
      else kind = 3;
    end
    check({ph, ":ready"}, 32'(eng_ready), 32'(er));
    check({ph, ":push"}, 32'(push), (kind == 1) ? 32'd1 : 32'd0);
    check({ph, ":uca2ucq"}, 32'(uca2ucq), (kind == 1) ? 32'(lit) : 32'd0);
    check({ph, ":conflict"}, 32'(conflict), 32'(m_conf));
    check({ph, ":conflict_lit"}, 32'(conflict_lit), 32'(m_clit));
    check({ph, ":dup_cnt"}, 32'(dup_cnt), 32'(m_dup));
    if (verbose && g >= 0)
      $display("[TB] %s eng=%0d lit=%0d %s", ph, g, lit,
               (kind == 1) ? "push" : (kind == 2) ? "dup" : "conflict");
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (clear) begin
      for (int k = 0; k < NV; k++) begin
        m_asg[k] = 1'b0;
        m_val[k] = 1'b0;
      end
      m_conf = 1'b0;
      m_clit = 0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (kind == 1) begin
        m_asg[v] = 1'b1;
        m_val[v] = p[0];
      end else if (kind == 2) begin
        if (m_dup < DUP_MAX) m_dup++;
      end else begin
        m_conf = 1'b1;
        m_clit = lit;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    full = 1'b0;
    eng_valid = '0;
    for (int i = 0; i < N; i++) lits[i] = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    step("reset");
    rst = 1'b0;
    step("idle");

    // First literal pushes the same cycle
    eng_valid = 4'b0001; lits[0] = 9'd10;
    step("first");
    eng_valid = 4'b0010; lits[1] = 9'd10;
    step("dup");
    check("dup_cnt_one", 32'(dup_cnt), 32'd1);
    eng_valid = 4'b0100; lits[2] = 9'd11;
    step("opposite");
    check("conflict_set", 32'(conflict), 32'd1);
    check("conflict_lit_11", 32'(conflict_lit), 32'd11);
    eng_valid = 4'b1111;
    step("blocked0");
    step("blocked1");

    // Clear, then walk the pointer back to 0
    eng_valid = 4'b0000;
    clear = 1'b1;
    step("clear");
    clear = 1'b0;
    eng_valid = 4'b1000; lits[3] = 9'd30;
    step("ptr_wrap");

    // All four engines at once: rotate 0,1,2,3
    lits[0] = 9'd2; lits[1] = 9'd4; lits[2] = 9'd6; lits[3] = 9'd8;
    eng_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      step("rotate");
      eng_valid[k] = 1'b0;
    end

    // Back-pressure
    full = 1'b1;
    eng_valid = 4'b1000; lits[3] = 9'd20;
    for (int k = 0; k < 3; k++) step("full");
    full = 1'b0;
    step("full_drop");
    eng_valid = '0;

    // Clear with a valid pending: no grant, then re-push
    eng_valid = 4'b0001; lits[0] = 9'd10;
    step("pre_clear");
    clear = 1'b1;
    step("clear_valid");
    clear = 1'b0;
    step("post_clear");
    check("post_clear_conflict", 32'(conflict), 32'd0);
    eng_valid = '0;

    // Random traffic with a small variable pool
    for (int c = 0; c < 2000; c++) begin
      eng_valid = N'($urandom);
      for (int i = 0; i < N; i++) lits[i] = LW'($urandom_range(0, 15));
      clear = ($urandom_range(0, 15) == 0);
      full  = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      step("rand");
    end
    clear = 1'b0;
    full = 1'b0;

    // Duplicate counter saturation
    rst = 1'b1;
    eng_valid = '0;
    step("sat_rst");
    rst = 1'b0;
    eng_valid = 4'b0001; lits[0] = 9'd10;
    step("sat_first");
    verbose = 1'b0;
    for (int c = 0; c < 65537; c++) step("sat");
    verbose = 1'b1;
    check("dup_saturated", 32'(dup_cnt), 32'd65535);

    // Reset mid-stream with the valid still held
    rst = 1'b1;
    step("mid_rst");
    step("after_rst");
    check("rst_dup_cnt", 32'(dup_cnt), 32'd0);
    check("rst_push", 32'(push), 32'd0);
    rst = 1'b0;
    step("resume");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_arbiter.md
# uc_arbiter

Unit-clause arbiter sitting directly upstream of the unit-clause queue (`uc_queue`). It collects unit-literal reports from `NUM_ENG` BCP engines and grants one per cycle in round-robin order. Each granted literal is checked against an assignment scoreboard: new literals are pushed into the queue, duplicates are dropped, and opposite-polarity hits raise a sticky conflict. It owns the `push`/`uca2ucq` side of the queue and honours the queue's `full`.

## Interface
Parameters:
- `NUM_ENG`, 4, number of reporting engines (power of two, ≥2)
- `UC_LENGTH`, 512, literal space; `LIT_W = $clog2(UC_LENGTH)` = 9
- `CNT_W`, 16, width of the duplicate counter

Ports:
- `clk`  in  1  single clock, all state on posedge
- `rst`  in  1  synchronous, active-high reset
- `eng_valid`  in  NUM_ENG  engine i has a unit literal
- `eng_lit`  in  NUM_ENG×LIT_W  literal per engine; bit0 = polarity (1 = negative), bits[LIT_W-1:1] = variable index
- `eng_ready`  out  NUM_ENG  one-hot grant; a literal is accepted when `eng_valid[i] & eng_ready[i]`
- `clear`  in  1  wipe the scoreboard and conflict state (new decision level)
- `full`  in  1  queue full
- `push`  out  1  push strobe to the queue
- `uca2ucq`  out  LIT_W  literal to the queue
- `conflict`  out  1  sticky conflict flag
- `conflict_lit`  out  LIT_W  the literal that caused the conflict
- `dup_cnt`  out  CNT_W  saturating count of dropped duplicates

## Operation
- Scoreboard: per variable (`UC_LENGTH/2` = 256 entries), an `assigned` bit and a `value` bit. Reset and `clear` zero all entries.
- Grant eligibility: `!rst & !clear & !full & !conflict`. When eligible, the first valid engine at or after `rr_ptr` (cyclic) gets `eng_ready`. At most one ready bit is high. A ready bit is never high without the matching valid.
- Granted literal L, variable v = L[LIT_W-1:1], polarity p = L[0]:
  - `!assigned[v]`: `push = 1`, `uca2ucq = L` in the same cycle. At the edge, set `assigned[v] = 1` and `value[v] = p`.
  - `assigned[v] & value[v] == p`: duplicate. No push; `dup_cnt` increments and saturates at all-ones.
  - `assigned[v] & value[v] != p`: conflict. No push. At the edge, `conflict = 1` and `conflict_lit = L`.
- After a grant, `rr_ptr` becomes the granted index + 1 (mod `NUM_ENG`). `rr_ptr` holds when there is no grant.
- `conflict` stays high, and all grants stay blocked, until `clear` or `rst`. `clear` zeroes the scoreboard, `conflict` and `conflict_lit`. It does not touch `rr_ptr` or `dup_cnt`.
- Priority: `rst` > `clear` > grant.

## Timing
- Reset values: `eng_ready = 0`, `push = 0`, `uca2ucq = 0`, `conflict = 0`, `conflict_lit = 0`, `dup_cnt = 0`, `rr_ptr = 0`, scoreboard all zero.
- Zero-cycle path: `eng_ready`, `push` and `uca2ucq` are combinational from inputs and state. The queue captures on the same edge the literal is accepted. `uca2ucq = 0` whenever `push = 0`.
- The scoreboard update is visible to the grant in the following cycle. Two engines reporting the same variable in one cycle are serialized by arbitration, so the second is judged against the updated entry.
- `full` high: no grant, no push, no state change. Grants resume in the cycle `full` drops.
- `clear` with valids in the same cycle: no grant. The cleared scoreboard is used from the next cycle.
- `rst` mid-stream: any in-progress accept is discarded, and all state returns to reset values at the edge.
- Throughput: one literal per cycle.

## Structure
- Shared package `uc_pkg`: `UC_LENGTH`, `UCQ_SIZE`, `NUM_ENG`, `LIT_W`, typedef `lit_t` (logic [LIT_W-1:0]), and helper functions `lit_var()` and `lit_pol()`.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and encoded `gnt_idx`.
- The scoreboard, conflict, counter and pointer logic live in `uc_arbiter`.

## Test plan
- Reset, then engine 0 valid with lit 10 (var 5, positive) → `eng_ready = 0001`, `push = 1`, `uca2ucq = 10` the same cycle; `rr_ptr = 1`.
- Engine 1 lit 10 next → ready, `push = 0`, `dup_cnt = 1`. Then engine 2 lit 11 → ready, `push = 0`; next cycle `conflict = 1`, `conflict_lit = 11`, and all ready bits stay low while valids are held.
- After `clear`, engines 0–3 all valid with lits 2, 4, 6, 8 and `rr_ptr = 0` → pushes 2, 4, 6, 8 in 4 consecutive cycles, one-hot ready rotating 0001 → 0010 → 0100 → 1000.
- `full = 1` with engine 3 valid lit 20 → no ready, no push for 3 cycles. Drop `full` → push 20 that cycle.
- `clear` asserted with engine 0 valid lit 10 (var 5 previously assigned) → no grant that cycle; next cycle push 10 again and `conflict = 0`.
- 65 537 duplicate reports of one literal → `dup_cnt` saturates at 65 535. Assert `rst` mid-stream → all outputs at reset values the next cycle.
